// File: rtl/logic_acc.sv
// Bitwise logic accumulator: folds OR/AND/XOR/NOR beats into one registered result.
// Optional parity output out_par is enabled by defining LOGIC_ACC_PARITY_EN.
module logic_acc #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             acc_first,
    input  logic             acc_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNTW-1:0]  out_cnt
`ifdef LOGIC_ACC_PARITY_EN
    ,
    output logic             out_par
`endif
);

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_e;
    typedef enum logic [1:0] {OP_OR, OP_AND, OP_XOR, OP_NOR} op_e;

    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [CNTW-1:0]   out_cnt_q, out_cnt_d;
    logic              in_fire;
    logic              restart;
    logic [WIDTH-1:0]  fold_data;
    logic [CNTW-1:0]   fold_cnt;

    function automatic logic [WIDTH-1:0] apply_op(input op_e f, input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        case (f)
            OP_OR:   apply_op = x | y;
            OP_AND:  apply_op = x & y;
            OP_XOR:  apply_op = x ^ y;
            default: apply_op = ~(x | y);
        endcase
    endfunction

    // A result leaving this cycle frees the output slot for a new beat immediately.
    assign in_ready  = (state_q != OUT) || out_ready;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (state_q == OUT);
    assign out_data  = out_data_q;
    assign out_cnt   = out_cnt_q;

    // Any beat outside ACCUM (IDLE, or OUT being drained) starts fresh from a op b.
    assign restart   = (state_q != ACCUM) || acc_first;
    assign fold_data = restart ? apply_op(op_e'(op), a, b) : apply_op(op_e'(op), acc_q, a);
    assign fold_cnt  = restart ? CNT_ONE : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE);

    // NOTE: every signal gets a default before any branch, so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_cnt_d  = out_cnt_q;
        if (state_q == OUT && out_ready) begin
            state_d = IDLE;
        end
        if (in_fire) begin
            if (acc_last) begin
                out_data_d = fold_data;
                out_cnt_d  = fold_cnt;
                state_d    = OUT;
            end else begin
                acc_d   = fold_data;
                cnt_d   = fold_cnt;
                state_d = ACCUM;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

`ifdef LOGIC_ACC_PARITY_EN
    logic out_par_q, out_par_d;

    assign out_par_d = ^out_data_d;
    assign out_par   = out_par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_par_q <= 1'b0;
        end else begin
            out_par_q <= out_par_d;
        end
    end
`endif

endmodule
